btn_cond: RTL and testbench
===========================

BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 SHALL have parameter N_BTN, default 2, number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, stable-sample count before an edge is accepted (10 ms at 100 MHz).
REQ-003 SHALL have parameter LONG_CYCLES, default 100_000_000, hold time before a long-press pulse is generated (1 s at 100 MHz); used only when BTN_LONG_PRESS_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port clear, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port btn_raw, input, N_BTN bits, asynchronous bouncing push-button levels, active-high.
REQ-007 SHALL have port btn_level, output, N_BTN bits, debounced button level.
REQ-008 SHALL have port btn_press, output, N_BTN bits, one-cycle pulse per accepted press; this is the source of the start/stop pulses consumed by the reaction timer.
REQ-009 SHALL have port btn_release, output, N_BTN bits, one-cycle pulse per accepted release.
REQ-010 SHALL have port btn_long, output, N_BTN bits, one-cycle long-press pulse; present in all builds.

Function
REQ-011 Each channel SHALL pass btn_raw[i] through a 2-flop synchronizer; s[i] is the second flop's output.
REQ-012 Each channel SHALL run its own FSM with states IDLE, WAIT_HIGH, HELD and WAIT_LOW, plus a counter wide enough for max(DEBOUNCE_CYCLES, LONG_CYCLES).
REQ-013 IDLE: when s=1, go to WAIT_HIGH and set the counter to 0; otherwise stay in IDLE.
REQ-014 WAIT_HIGH: when s=0, return to IDLE with no pulse. When s=1 and the counter equals DEBOUNCE_CYCLES-1, go to HELD and register btn_press=1 for exactly one cycle. Otherwise, increment the counter.
REQ-015 HELD: btn_level=1. When s=0, go to WAIT_LOW and set the counter to 0.
REQ-016 WAIT_LOW: when s=1, return to HELD with no pulse. When s=0 and the counter equals DEBOUNCE_CYCLES-1, go to IDLE and register btn_release=1 for one cycle. Otherwise, increment the counter.
REQ-017 Latency: with btn_raw stable high from clock edge 0 (the first edge that samples it high), btn_press SHALL be high in the cycle following edge DEBOUNCE_CYCLES+2. Release latency SHALL be the same.
REQ-018 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no pulse and SHALL restart qualification from zero at the next stable sample.
REQ-019 Channels SHALL be fully independent. Simultaneous presses on several channels SHALL pulse in the same cycle.
REQ-020 btn_press, btn_release and btn_long SHALL be mutually exclusive per channel in any cycle.
REQ-021 The counter SHALL saturate and never wrap.
REQ-022 A button held through reset SHALL be treated as a new press after reset: it requalifies through WAIT_HIGH.

Reset
REQ-023 On clear=1 at a clock edge, all FSMs SHALL go to IDLE, and the counters and synchronizer flops SHALL go to 0.
REQ-024 The cycle after reset, all outputs SHALL be 0: btn_level, btn_press, btn_release and btn_long.
REQ-025 A reset asserted mid-qualification or mid-hold SHALL discard the pending pulse; no pulse SHALL be emitted on the reset cycle.

Configuration
REQ-026 The macro BTN_LONG_PRESS_EN SHALL select the long-press feature.
REQ-027 With BTN_LONG_PRESS_EN defined: in HELD, the counter increments from 0 at entry. When it reaches LONG_CYCLES-1, btn_long SHALL pulse once; no repeat until a release is accepted.
REQ-028 Without BTN_LONG_PRESS_EN, btn_long SHALL be tied to 0 and no long-press counter logic SHALL be synthesized.

Structure
REQ-029 The package btn_pkg SHALL hold the channel state enum (IDLE, WAIT_HIGH, HELD, WAIT_LOW) and the default cycle constants.
REQ-030 The sub-module btn_chan SHALL implement one channel (synchronizer, FSM, counter); btn_cond SHALL instantiate N_BTN copies in a generate loop.

Verification
REQ-031 The bench SHALL use DEBOUNCE_CYCLES=4, LONG_CYCLES=20 and N_BTN=2.
REQ-032 Clean press: btn_raw[0] rises at edge 0 and holds. Required: btn_press[0] high only after edge 6, btn_level[0]=1 thereafter, btn_press[1]=0.
REQ-033 Bounce: btn_raw[0] goes 1,1,0,1,0 for one cycle each, then 0. Required: no btn_press and no btn_level change.
REQ-034 Release: a held button drops at edge N and stays low. Required: a single btn_release pulse after edge N+6 and btn_level=0.
REQ-035 Simultaneous: both btn_raw bits rise at the same edge. Required: btn_press=2'b11 in the same single cycle.
REQ-036 Reset mid-operation: clear asserted during WAIT_HIGH (edge 4). Required: no pulse and all outputs 0 the next cycle. With the button still high after clear deasserts at edge K, btn_press pulses after edge K+7 (K+1 first samples the button, plus DEBOUNCE_CYCLES+2).
REQ-037 Long press, with BTN_LONG_PRESS_EN: hold for 40 cycles after press. Required: exactly one btn_long pulse, 20 cycles after HELD entry. Without the macro, btn_long stays 0.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and defaults for the button conditioner: channel state encoding,
// default timing constants and the counter-width helper.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        HELD      = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_e;

    localparam int unsigned DEF_N_BTN           = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_LONG_CYCLES     = 100_000_000;

    // Width able to hold max(a, b) without wrapping; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM and shared saturating counter.
// Long-press detection is built only when BTN_LONG_PRESS_EN is defined.
//
// state     | meaning
// ----------|---------------------------------------------------------------
// IDLE      | released and stable, waiting for a high sample
// WAIT_HIGH | qualifying a press; counter counts stable high samples
// HELD      | press accepted; counter times the long press (when enabled)
// WAIT_LOW  | qualifying a release; counter counts stable low samples
`default_nettype none
module btn_chan
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk_i,
    input  logic clear_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic rel_o,
    output logic long_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic          sync1_q;
    logic          sync2_q;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    logic long_q, long_d;
    logic long_done_q, long_done_d;
`endif

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
`ifdef BTN_LONG_PRESS_EN
        long_d      = 1'b0;
        long_done_d = long_done_q;
`endif
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end else begin
`ifdef BTN_LONG_PRESS_EN
                    // One pulse per accepted press; the flag clears only on release.
                    if (cnt_q == LONG_LAST && !long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                    cnt_d = cnt_inc;
`endif
                end
            end
            WAIT_LOW: begin
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    cnt_d   = '0;
`ifdef BTN_LONG_PRESS_EN
                    long_done_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            long_q      <= 1'b0;
            long_done_q <= 1'b0;
        end else begin
            long_q      <= long_d;
            long_done_q <= long_done_d;
        end
    end
    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

    // Level stays high while a release is still being qualified.
    assign level_o = (state_q == HELD) || (state_q == WAIT_LOW);
    assign press_o = press_q;
    assign rel_o   = rel_q;

endmodule
`default_nettype wire

// File: rtl/btn_cond.sv
// Multi-channel push-button conditioner: N_BTN independent btn_chan instances.
// Define BTN_LONG_PRESS_EN to build the long-press pulse; otherwise btn_long is 0.
`default_nettype none
module btn_cond
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = DEF_N_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar g = 0; g < int'(N_BTN); g++) begin : g_chan
        btn_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .clk_i   (clk),
            .clear_i (clear),
            .raw_i   (btn_raw[g]),
            .level_o (btn_level[g]),
            .press_o (btn_press[g]),
            .rel_o   (btn_release[g]),
            .long_o  (btn_long[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_cond.sv
// Scoreboard bench for btn_cond: a run-length reference model predicts every cycle's
// outputs; a monitor pops and compares them one cycle later.
`timescale 1ns/1ps
module tb_btn_cond;

    localparam int N    = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic         clk = 1'b0;
    logic         clear;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

    btn_cond #(.N_BTN(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
        .clk         (clk),
        .clear       (clear),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rls;
        logic [N-1:0] lng;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference model: the synchronized sample is the raw input two edges late; a level
    // flips after DEB+1 consecutive samples disagreeing with it; long press fires after
    // LONG consecutive high samples following acceptance (or following a bounce back).
    logic [N-1:0] m_s1 = '0, m_s = '0, m_prev = '0, m_level = '0;
    int           m_run[N];
    int           m_ls[N];
    bit           m_done[N];

    task step(input logic c, input logic [N-1:0] r);
        exp_t e;
        logic sv;
        clear   = c;
        btn_raw = r;
        e = '0;
        if (c) begin
            m_s1 = '0; m_s = '0; m_prev = '0; m_level = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0; m_ls[i] = 0; m_done[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                sv = m_s[i];
                if (!m_level[i]) begin
                    m_run[i] = sv ? m_run[i] + 1 : 0;
                    if (m_run[i] == DEB + 1) begin
                        e.prs[i]   = 1'b1;
                        m_level[i] = 1'b1;
                        m_run[i]   = 0;
                        m_ls[i]    = 0;
                    end
                end else begin
                    if (sv && m_prev[i]) begin
                        if (m_ls[i] <= LONG) m_ls[i]++;
`ifdef BTN_LONG_PRESS_EN
                        if (m_ls[i] == LONG && !m_done[i]) begin
                            e.lng[i]  = 1'b1;
                            m_done[i] = 1;
                        end
`endif
                    end else begin
                        m_ls[i] = 0;
                    end
                    m_run[i] = sv ? 0 : m_run[i] + 1;
                    if (m_run[i] == DEB + 1) begin
                        e.rls[i]   = 1'b1;
                        m_level[i] = 1'b0;
                        m_run[i]   = 0;
                        m_done[i]  = 0;
                    end
                end
                m_prev[i] = sv;
            end
            m_s  = m_s1;
            m_s1 = r;
        end
        e.lvl = m_level;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task repeat_step(input logic c, input logic [N-1:0] r, input int n);
        for (int k = 0; k < n; k++) step(c, r);
    endtask

    // Monitor: one expectation per clock, compared 1 ns after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                n_vec++;
                if ({btn_level, btn_press, btn_release, btn_long} !== x) begin
                    n_mis++;
                    $display("FAIL outputs t=%0t: got lvl=%b prs=%b rel=%b lng=%b, want lvl=%b prs=%b rel=%b lng=%b",
                             $time, btn_level, btn_press, btn_release, btn_long,
                             x.lvl, x.prs, x.rls, x.lng);
                end
                n_vec++;
                if (((btn_press & btn_release) | (btn_press & btn_long) | (btn_release & btn_long)) !== '0) begin
                    n_mis++;
                    $display("FAIL exclusive t=%0t: prs=%b rel=%b lng=%b, want no overlap",
                             $time, btn_press, btn_release, btn_long);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           dur[N];
        logic [N-1:0] cur;
        clear   = 1'b1;
        btn_raw = '0;
        repeat_step(1'b1, 2'b00, 3);

        // Clean press on channel 0, then release
        repeat_step(1'b0, 2'b01, 12);
        repeat_step(1'b0, 2'b00, 10);

        // Bounce 1,1,0,1,0 then low
        step(1'b0, 2'b01); step(1'b0, 2'b01); step(1'b0, 2'b00);
        step(1'b0, 2'b01); step(1'b0, 2'b00);
        repeat_step(1'b0, 2'b00, 8);

        // Simultaneous press and release on both channels
        repeat_step(1'b0, 2'b11, 10);
        repeat_step(1'b0, 2'b00, 10);

        // Clear during press qualification, button kept high through and after
        repeat_step(1'b0, 2'b01, 4);
        step(1'b1, 2'b01);
        repeat_step(1'b0, 2'b01, 12);
        repeat_step(1'b0, 2'b00, 10);

        // Clear while held
        repeat_step(1'b0, 2'b10, 9);
        step(1'b1, 2'b10);
        repeat_step(1'b0, 2'b00, 6);

        // Long hold: 40 cycles past acceptance
        repeat_step(1'b0, 2'b01, 6 + 40);
        repeat_step(1'b0, 2'b00, 10);

        // Long hold with a short dip while held
        repeat_step(1'b0, 2'b01, 16);
        repeat_step(1'b0, 2'b00, 2);
        repeat_step(1'b0, 2'b01, 30);
        repeat_step(1'b0, 2'b00, 10);

        // Randomized levels with mixed short bounces and long holds
        for (int i = 0; i < N; i++) dur[i] = 0;
        cur = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (dur[i] == 0) begin
                    cur[i] = 1'($urandom_range(0, 1));
                    dur[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                         : int'($urandom_range(1, 8));
                end
                dur[i]--;
            end
            step(($urandom_range(0, 199) == 0), cur);
        end
        repeat_step(1'b0, 2'b00, 10);

        @(posedge clk);
        #3;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
